// File: rtl/fma_aligner.sv
// fma_aligner: exponent-alignment stage feeding the FMA accumulate adder.
// Takes two operands in normalized accumulator format, aligns both to the
// larger exponent and emits two sign-extended (M+2)-bit mantissas plus the
// common exponent. The downstream adder can sum them directly without overflow.
// SINGLE_STAGE=1 merges compare and shift into one register stage (latency 1);
// SINGLE_STAGE=0 gives two register stages (latency 2).
// Optional macro FMA_ALIGN_STICKY_EN: OR the bits shifted out of the small
// operand into its LSB so a non-zero operand never vanishes; when undefined the
// shift truncates (round toward -inf).

package fma_aligner_pkg;
  localparam int EXP_W  = 8;
  localparam int MANT_W = 16;

  typedef logic [EXP_W-1:0]         exponent_t;
  typedef logic signed [MANT_W-1:0] accMantNormalSigned_t;

  typedef struct packed {
    exponent_t            Exp;
    accMantNormalSigned_t Mant;
  } accNormalSigned_t;

  localparam exponent_t EXP_MAX = '1;
endpackage

module fma_aligner
  import fma_aligner_pkg::*;
#(
  parameter bit SINGLE_STAGE = 1'b0
) (
  input  logic                                   clk,
  input  logic                                   rst_n,
  input  logic                                   in_valid,
  output logic                                   in_ready,
  input  logic [$bits(accNormalSigned_t)-1:0]    a_in,
  input  logic [$bits(accNormalSigned_t)-1:0]    b_in,
  output logic                                   out_valid,
  input  logic                                   out_ready,
  output logic [$bits(exponent_t)-1:0]           exp_out,
  output logic [$bits(accMantNormalSigned_t)+1:0] mant_a_out,
  output logic [$bits(accMantNormalSigned_t)+1:0] mant_b_out,
  output logic                                   is_inf_out
);

  localparam int M = $bits(accMantNormalSigned_t);
  localparam int E = $bits(exponent_t);
  localparam int W = M + 2;

  accNormalSigned_t a_op, b_op;
  assign a_op = a_in;
  assign b_op = b_in;

  // Handshake: stage 1 can take a new pair whenever it is empty or draining.
  logic s1_advance;
  logic in_fire;

  logic                 s1_valid_q;
  accMantNormalSigned_t s1_big_q, s1_small_q;
  logic [E:0]           s1_diff_q;
  logic                 s1_swap_q;
  exponent_t            s1_exp_q;
  logic                 s1_inf_q;

  assign in_ready = !s1_valid_q || s1_advance;
  assign in_fire  = in_valid && in_ready;

  // Stage 1 compare: pick the larger exponent and the absolute difference.
  logic                 swap_d;
  logic [E:0]           diff_d;
  accMantNormalSigned_t big_mant_d, small_mant_d;
  exponent_t            max_exp_d;
  logic                 inf_d;

  always_comb begin
    // NOTE: every always_comb output gets a value on every path, otherwise a latch is inferred.
    swap_d       = b_op.Exp > a_op.Exp;
    diff_d       = swap_d ? ({1'b0, b_op.Exp} - {1'b0, a_op.Exp})
                          : ({1'b0, a_op.Exp} - {1'b0, b_op.Exp});
    big_mant_d   = swap_d ? b_op.Mant : a_op.Mant;
    small_mant_d = swap_d ? a_op.Mant : b_op.Mant;
    max_exp_d    = swap_d ? b_op.Exp : a_op.Exp;
    inf_d        = (a_op.Exp == EXP_MAX) || (b_op.Exp == EXP_MAX);
  end

  // Stage 1 register: captures the compare result on an input transfer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: data registers are reset too, because in the single-stage build they drive the outputs directly.
      s1_valid_q <= 1'b0;
      s1_big_q   <= '0;
      s1_small_q <= '0;
      s1_diff_q  <= '0;
      s1_swap_q  <= 1'b0;
      s1_exp_q   <= '0;
      s1_inf_q   <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      if (in_fire)         s1_valid_q <= 1'b1;
      else if (s1_advance) s1_valid_q <= 1'b0;
      if (in_fire) begin
        s1_big_q   <= big_mant_d;
        s1_small_q <= small_mant_d;
        s1_diff_q  <= diff_d;
        s1_swap_q  <= swap_d;
        s1_exp_q   <= max_exp_d;
        s1_inf_q   <= inf_d;
      end
    end
  end

  // Stage 2 shift: saturating arithmetic right shift of the small operand, un-swap, inf override.
  logic signed [W-1:0] big_ext, small_ext, small_sh;
  logic [W-1:0]        mant_a_d, mant_b_d;
  exponent_t           exp_d;
`ifdef FMA_ALIGN_STICKY_EN
  logic [W-1:0]        lost_mask;
`endif

  always_comb begin
    big_ext   = {{2{s1_big_q[M-1]}}, s1_big_q};
    small_ext = {{2{s1_small_q[M-1]}}, s1_small_q};
    if (s1_diff_q >= (E+1)'(W)) begin
      small_sh = {W{small_ext[W-1]}};
    end else begin
      small_sh = small_ext >>> s1_diff_q;
    end
`ifdef FMA_ALIGN_STICKY_EN
    if (s1_diff_q >= (E+1)'(W)) lost_mask = '1;
    else                        lost_mask = ~({W{1'b1}} << s1_diff_q);
    small_sh[0] = small_sh[0] | (|(small_ext & lost_mask));
`endif
    if (s1_inf_q) begin
      exp_d    = EXP_MAX;
      mant_a_d = '0;
      mant_b_d = '0;
    end else begin
      exp_d    = s1_exp_q;
      mant_a_d = s1_swap_q ? small_sh : big_ext;
      mant_b_d = s1_swap_q ? big_ext  : small_sh;
    end
  end

  if (SINGLE_STAGE) begin : g_single
    assign s1_advance = out_ready;
    assign out_valid  = s1_valid_q;
    assign exp_out    = exp_d;
    assign mant_a_out = mant_a_d;
    assign mant_b_out = mant_b_d;
    assign is_inf_out = s1_inf_q;
  end else begin : g_two
    logic         s2_valid_q;
    exponent_t    s2_exp_q;
    logic [W-1:0] s2_mant_a_q, s2_mant_b_q;
    logic         s2_inf_q;

    assign s1_advance = !s2_valid_q || out_ready;

    // Stage 2 register: loads when the output is empty or being accepted, else holds.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        s2_valid_q  <= 1'b0;
        s2_exp_q    <= '0;
        s2_mant_a_q <= '0;
        s2_mant_b_q <= '0;
        s2_inf_q    <= 1'b0;
      end else if (s1_advance) begin
        s2_valid_q <= s1_valid_q;
        if (s1_valid_q) begin
          s2_exp_q    <= exp_d;
          s2_mant_a_q <= mant_a_d;
          s2_mant_b_q <= mant_b_d;
          s2_inf_q    <= s1_inf_q;
        end
      end
    end

    assign out_valid  = s2_valid_q;
    assign exp_out    = s2_exp_q;
    assign mant_a_out = s2_mant_a_q;
    assign mant_b_out = s2_mant_b_q;
    assign is_inf_out = s2_inf_q;
  end

endmodule

// File: tb/tb_fma_aligner.sv
// Scoreboard bench for fma_aligner (M=16, 8-bit exponent, EXP_MAX=255).
// Stimulus pushes hand-computed expectations; a negedge monitor pops and
// compares on every output transfer and checks stability while stalled.
module tb_fma_aligner;
  localparam bit SS  = 1'b0;
  localparam int LAT = SS ? 1 : 2;
`ifdef FMA_ALIGN_STICKY_EN
  localparam bit STICKY = 1'b1;
`else
  localparam bit STICKY = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n, in_valid, in_ready, out_valid, out_ready, is_inf_out;
  logic [23:0] a_in, b_in;
  logic [7:0]  exp_out;
  logic [17:0] mant_a_out, mant_b_out;

  fma_aligner #(.SINGLE_STAGE(SS)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a_in(a_in), .b_in(b_in), .out_valid(out_valid), .out_ready(out_ready),
    .exp_out(exp_out), .mant_a_out(mant_a_out), .mant_b_out(mant_b_out),
    .is_inf_out(is_inf_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  ea; logic [15:0] ma;
    logic [7:0]  eb; logic [15:0] mb;
    logic [7:0]  xe; logic [17:0] xa; logic [17:0] xb; logic xi;
  } vec_t;

  typedef struct packed {
    logic [7:0]  e;
    logic [17:0] a;
    logic [17:0] b;
    logic        inf;
  } exp_t;

  vec_t vecs[$];
  exp_t sb_q[$];
  int   xfer_cyc[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   ready_mode = 0;  // 0: held high, 1: pseudo-random, 2: held low

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic add(input logic [7:0] ea, input logic [15:0] ma,
                     input logic [7:0] eb, input logic [15:0] mb,
                     input logic [7:0] xe, input logic [17:0] xa,
                     input logic [17:0] xb, input logic xi);
    vec_t v;
    v.ea = ea; v.ma = ma; v.eb = eb; v.mb = mb;
    v.xe = xe; v.xa = xa; v.xb = xb; v.xi = xi;
    vecs.push_back(v);
  endtask

  // Called at posedge+#1; returns at posedge+#1 right after acceptance.
  task automatic send(input vec_t v, output int acc_cyc);
    int guard;
    exp_t e;
    guard = 0;
    a_in = {v.ea, v.ma};
    b_in = {v.eb, v.mb};
    in_valid = 1'b1;
    e.e = v.xe; e.a = v.xa; e.b = v.xb; e.inf = v.xi;
    sb_q.push_back(e);
    do begin
      @(negedge clk);
      guard++;
    end while (!in_ready && guard < 500);
    if (!in_ready) begin
      $display("FAIL send_timeout: in_ready stuck low after %0d cycles", guard);
      $fatal(1);
    end
    @(posedge clk);
    #1;
    acc_cyc = cyc;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int guard;
    guard = 0;
    while (sb_q.size() != 0 && guard < 300) begin
      @(posedge clk);
      guard++;
    end
    #1;
    check("drain_empty", sb_q.size(), 0);
  endtask

  // Output-ready driver.
  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        1:       out_ready = 1'($urandom_range(0, 1));
        2:       out_ready = 1'b0;
        default: out_ready = 1'b1;
      endcase
    end
  end

  // Monitor: pops the scoreboard on every output transfer, checks hold while stalled.
  exp_t held;
  logic stalled = 1'b0;
  always @(negedge clk) begin
    if (!rst_n) begin
      stalled = 1'b0;
    end else begin
      if (stalled) begin
        check("stall_valid", out_valid, 1);
        check("stall_data", {exp_out, mant_a_out, mant_b_out, is_inf_out}, held);
      end
      if (out_valid && out_ready) begin
        xfer_cyc.push_back(cyc);
        if (sb_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_output: exp %0h a %0h b %0h with empty scoreboard",
                   exp_out, mant_a_out, mant_b_out);
        end else begin
          exp_t e;
          e = sb_q.pop_front();
          check("exp_out", exp_out, e.e);
          check("mant_a_out", mant_a_out, e.a);
          check("mant_b_out", mant_b_out, e.b);
          check("is_inf_out", is_inf_out, e.inf);
        end
        stalled = 1'b0;
      end else if (out_valid) begin
        stalled = 1'b1;
        held = {exp_out, mant_a_out, mant_b_out, is_inf_out};
      end else begin
        stalled = 1'b0;
      end
    end
  end

  initial begin
    int acc;
    int acc_c[4];
    int n0;
    rst_n = 1'b0; in_valid = 1'b0; a_in = '0; b_in = '0;

    //   A.Exp A.Mant    B.Exp B.Mant    exp   mant_a                      mant_b                      inf
    add(8'd100, 16'h4000, 8'd100, 16'hC000, 8'd100, 18'h04000,                18'h3C000,                  1'b0);
    add(8'd97,  16'h4000, 8'd100, 16'h4000, 8'd100, 18'h00800,                18'h04000,                  1'b0);
    add(8'd100, 16'h4000, 8'd96,  16'h8000, 8'd100, 18'h04000,                18'h3F800,                  1'b0);
    add(8'd200, 16'h4000, 8'd10,  16'hC001, 8'd200, 18'h04000,                18'h3FFFF,                  1'b0);
    add(8'd200, 16'h4000, 8'd10,  16'h0001, 8'd200, 18'h04000,                STICKY ? 18'h1 : 18'h0,     1'b0);
    add(8'd88,  16'h4001, 8'd100, 16'h1234, 8'd100, STICKY ? 18'h5 : 18'h4,   18'h01234,                  1'b0);
    add(8'd100, 16'h0000, 8'd98,  16'hFFF9, 8'd100, 18'h00000,                STICKY ? 18'h3FFFF : 18'h3FFFE, 1'b0);
    add(8'd255, 16'h4000, 8'd10,  16'h1234, 8'd255, 18'h00000,                18'h00000,                  1'b1);
    add(8'd3,   16'h7000, 8'd255, 16'hC000, 8'd255, 18'h00000,                18'h00000,                  1'b1);
    add(8'd50,  16'h0000, 8'd40,  16'h3000, 8'd50,  18'h00000,                18'h0000C,                  1'b0);
    add(8'd30,  16'h0000, 8'd60,  16'h2000, 8'd60,  18'h00000,                18'h02000,                  1'b0);
    add(8'd70,  16'h0000, 8'd90,  16'h0000, 8'd90,  18'h00000,                18'h00000,                  1'b0);
    add(8'd120, 16'hA000, 8'd118, 16'h7FFF, 8'd120, 18'h3A000,                18'h01FFF,                  1'b0);
    add(8'd0,   16'h8000, 8'd18,  16'h0002, 8'd18,  18'h3FFFF,                18'h00002,                  1'b0);
    add(8'd37,  16'h7FFF, 8'd20,  16'h7FFF, 8'd37,  18'h07FFF,                STICKY ? 18'h1 : 18'h0,     1'b0);

    // Reset state.
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_exp_out", exp_out, 0);
    check("rst_mant_a", mant_a_out, 0);
    check("rst_mant_b", mant_b_out, 0);
    check("rst_is_inf", is_inf_out, 0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Latency of a single transfer from idle.
    send(vecs[0], acc);
    for (int i = 1; i < LAT; i++) begin
      @(negedge clk);
      check("latency_early", out_valid, 0);
    end
    @(negedge clk);
    check("latency_arrive", out_valid, 1);
    @(posedge clk);
    #1;
    drain();

    // All directed vectors under random back-pressure.
    ready_mode = 1;
    foreach (vecs[i]) send(vecs[i], acc);
    drain();

    // Full throughput with out_ready held high.
    ready_mode = 0;
    repeat (2) @(posedge clk);
    #1;
    n0 = xfer_cyc.size();
    for (int i = 0; i < 4; i++) send(vecs[i + 1], acc_c[i]);
    drain();
    for (int i = 1; i < 4; i++) begin
      check("accept_gap", acc_c[i] - acc_c[i-1], 1);
      check("output_gap", xfer_cyc[n0 + i] - xfer_cyc[n0 + i - 1], 1);
    end

    // Reset with two results in flight.
    ready_mode = 2;
    repeat (2) @(posedge clk);
    #1;
    send(vecs[1], acc);
    send(vecs[2], acc);
    @(negedge clk);
    check("inflight_valid", out_valid, 1);
    check("full_in_ready", in_ready, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("mid_rst_out_valid", out_valid, 0);
    check("mid_rst_exp_out", exp_out, 0);
    check("mid_rst_mant_a", mant_a_out, 0);
    check("mid_rst_mant_b", mant_b_out, 0);
    check("mid_rst_is_inf", is_inf_out, 0);
    sb_q.delete();
    ready_mode = 0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (5) begin
      @(negedge clk);
      check("no_stale_output", out_valid, 0);
    end
    @(posedge clk);
    #1;
    send(vecs[3], acc);
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
